// File: rtl/sgpr_arb_pkg.sv
// Shared constants and types for the SGPR port arbiters.
// Requester numbering: simd0..3 = 0..3, simf0..3 = 4..7.
package sgpr_arb_pkg;

    localparam int NUM_VFU     = 8;
    localparam int SGPR_ADDR_W = 9;

    localparam int SIMD0 = 0;
    localparam int SIMD1 = 1;
    localparam int SIMD2 = 2;
    localparam int SIMD3 = 3;
    localparam int SIMF0 = 4;
    localparam int SIMF1 = 5;
    localparam int SIMF2 = 6;
    localparam int SIMF3 = 7;

    typedef logic [NUM_VFU-1:0] fu_vec_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping to 0. Shared by the SGPR read and write port arbiters.
module rr_priority_pick
    import sgpr_arb_pkg::*;
#(
    parameter int N  = NUM_VFU,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        int  j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sgpr_rd_arbiter.sv
// Round-robin arbiter sharing the SGPR vector read port among the
// SIMD/SIMF units, with one buffered request per unit.
module sgpr_rd_arbiter
    import sgpr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_VFU,
    parameter int ADDR_W  = SGPR_ADDR_W,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_en,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic                      sgpr_rd_en,
    output logic [ADDR_W-1:0]         sgpr_rd_addr,
    output logic [NUM_REQ-1:0]        rfa_select_fu,
    output logic [NUM_REQ-1:0]        rd_data_valid,
    output logic                      ovf_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] pending;
    logic [ADDR_W-1:0]  addr_buf [NUM_REQ];
    logic [IW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] vpipe [RD_LAT];
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      g_idx;
    logic               g_any;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (pending),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (g_idx)
    );

    assign g_any         = |gnt;
    assign req_busy      = pending;
    assign sgpr_rd_en    = g_any;
    assign rfa_select_fu = gnt;
    assign sgpr_rd_addr  = g_any ? addr_buf[g_idx] : '0;
    assign rd_data_valid = vpipe[RD_LAT-1];

    // A unit may re-request in its own grant cycle; its slot frees that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                addr_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_en[i] && (!pending[i] || gnt[i])) begin
                    pending[i]  <= 1'b1;
                    addr_buf[i] <= req_addr[i*ADDR_W +: ADDR_W];
                end else if (gnt[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
        end else if (|(req_en & pending & ~gnt)) begin
            ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (g_any) begin
            rr_ptr <= (g_idx == IW'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vpipe[k] <= '0;
            end
        end else begin
            vpipe[0] <= gnt;
            for (int k = 1; k < RD_LAT; k++) begin
                vpipe[k] <= vpipe[k-1];
            end
        end
    end

endmodule

// File: tb/tb_sgpr_rd_arbiter.sv
// Directed bench for sgpr_rd_arbiter with a grant scoreboard
// and a per-cycle monitor for grant order, valid timing and invariants.
module tb_sgpr_rd_arbiter;
    import sgpr_arb_pkg::*;

    localparam int N = NUM_VFU;
    localparam int W = SGPR_ADDR_W;

    logic            clk;
    logic            rst;
    fu_vec_t         req_en;
    logic [N*W-1:0]  req_addr;
    fu_vec_t         req_busy;
    logic            sgpr_rd_en;
    logic [W-1:0]    sgpr_rd_addr;
    fu_vec_t         rfa_select_fu;
    fu_vec_t         rd_data_valid;
    logic            ovf_err;

    typedef struct {
        fu_vec_t      sel;
        logic [W-1:0] addr;
        int           rdy;
    } exp_t;

    exp_t    sb [$];
    int      checks;
    int      errors;
    int      cyc;
    fu_vec_t exp_prev;

    sgpr_rd_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_en        (req_en),
        .req_addr      (req_addr),
        .req_busy      (req_busy),
        .sgpr_rd_en    (sgpr_rd_en),
        .sgpr_rd_addr  (sgpr_rd_addr),
        .rfa_select_fu (rfa_select_fu),
        .rd_data_valid (rd_data_valid),
        .ovf_err       (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic req(input int u, input int a, input bit push);
        exp_t e;
        req_en[u] = 1'b1;
        req_addr[u*W +: W] = W'(a);
        if (push) begin
            e.sel  = fu_vec_t'(1) << u;
            e.addr = W'(a);
            e.rdy  = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic clr();
        req_en = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        fu_vec_t cur;
        exp_t    e;
        cur = '0;
        if (!rst) begin
            exp_prev = '0;
        end else begin
            chk("sel_onehot", 32'($onehot0(rfa_select_fu)), 1);
            chk("valid_onehot", 32'($onehot0(rd_data_valid)), 1);
            chk("en_vs_sel", sgpr_rd_en, |rfa_select_fu);
            chk("valid_pipe", rd_data_valid, exp_prev);
            if (sgpr_rd_en) begin
                if (sb.size() == 0) begin
                    chk("unexp_grant", rfa_select_fu, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_sel", rfa_select_fu, e.sel);
                    chk("sb_addr", sgpr_rd_addr, e.addr);
                    cur = e.sel;
                end
            end else if (sb.size() > 0 && sb[0].rdy <= cyc) begin
                chk("grant_stall", sgpr_rd_en, 1);
            end
            exp_prev = cur;
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        exp_prev = '0;
        rst      = 1'b0;
        req_en   = '0;
        req_addr = '0;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_en", sgpr_rd_en, 0);
        chk("rst_addr", sgpr_rd_addr, 0);
        chk("rst_sel", rfa_select_fu, 0);
        chk("rst_valid", rd_data_valid, 0);
        chk("rst_busy", req_busy, 0);
        chk("rst_ovf", ovf_err, 0);
        next();
        rst = 1'b1;

        for (int i = 0; i < N; i++) req(i, 10 + i, 1'b1);
        mid();
        chk("all_busy_pre", req_busy, 0);
        chk("all_en_pre", sgpr_rd_en, 0);
        next();
        clr();
        for (int i = 0; i < N; i++) begin
            mid();
            chk("all_sel", rfa_select_fu, fu_vec_t'(1) << i);
            chk("all_addr", sgpr_rd_addr, 10 + i);
            if (i == 0) chk("all_busy", req_busy, 8'hff);
            next();
        end
        mid();
        chk("all_valid_last", rd_data_valid, 8'h80);
        chk("all_idle", sgpr_rd_en, 0);
        next();

        req(0, 1, 1'b1);
        req(7, 2, 1'b1);
        next();
        clr();
        mid();
        chk("ptr0_first", rfa_select_fu, 8'h01);
        next();
        mid();
        chk("ptr0_second", rfa_select_fu, 8'h80);
        next();

        req(SIMF1, 100, 1'b1);
        mid();
        chk("one_busy_c", req_busy, 0);
        next();
        clr();
        mid();
        chk("one_en", sgpr_rd_en, 1);
        chk("one_addr", sgpr_rd_addr, 100);
        chk("one_sel", rfa_select_fu, 8'h20);
        chk("one_busy", req_busy, 8'h20);
        next();
        mid();
        chk("one_valid", rd_data_valid, 8'h20);
        chk("one_busy_after", req_busy, 0);
        chk("one_en_after", sgpr_rd_en, 0);
        next();

        req(6, 3, 1'b1);
        next();
        clr();
        mid();
        chk("wrap_g6", rfa_select_fu, 8'h40);
        next();
        req(7, 21, 1'b1);
        req(0, 20, 1'b1);
        next();
        clr();
        mid();
        chk("wrap_g7", rfa_select_fu, 8'h80);
        chk("wrap_a7", sgpr_rd_addr, 21);
        next();
        mid();
        chk("wrap_g0", rfa_select_fu, 8'h01);
        chk("wrap_a0", sgpr_rd_addr, 20);
        next();

        req(1, 40, 1'b1);
        req(2, 50, 1'b1);
        next();
        clr();
        req(2, 60, 1'b0);
        mid();
        chk("ovf_g1", rfa_select_fu, 8'h02);
        chk("ovf_pre", ovf_err, 0);
        next();
        clr();
        mid();
        chk("ovf_g2", rfa_select_fu, 8'h04);
        chk("ovf_a2", sgpr_rd_addr, 50);
        chk("ovf_set", ovf_err, 1);
        next();
        mid();
        chk("ovf_sticky", ovf_err, 1);
        chk("ovf_busy", req_busy, 0);
        next();

        do_reset();
        mid();
        chk("ovf_cleared", ovf_err, 0);
        next();

        req(SIMD3, 70, 1'b1);
        next();
        clr();
        req(SIMD3, 77, 1'b1);
        mid();
        chk("rereq_g1", rfa_select_fu, 8'h08);
        chk("rereq_a1", sgpr_rd_addr, 70);
        next();
        clr();
        mid();
        chk("rereq_busy", req_busy, 8'h08);
        chk("rereq_g2", rfa_select_fu, 8'h08);
        chk("rereq_a2", sgpr_rd_addr, 77);
        chk("rereq_ovf", ovf_err, 0);
        next();
        mid();
        chk("rereq_done", req_busy, 0);
        chk("rereq_ovf2", ovf_err, 0);
        next();

        for (int i = 0; i < 5; i++) req(i, 80 + i, i == 4);
        next();
        clr();
        mid();
        chk("mid_g4", rfa_select_fu, 8'h10);
        chk("mid_busy", req_busy, 8'h1f);
        next();
        chk("mid_inflight", rd_data_valid, 8'h10);
        chk("mid_pend4", req_busy, 8'h0f);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("arst_en", sgpr_rd_en, 0);
        chk("arst_sel", rfa_select_fu, 0);
        chk("arst_addr", sgpr_rd_addr, 0);
        chk("arst_valid", rd_data_valid, 0);
        chk("arst_busy", req_busy, 0);
        @(negedge clk);
        next();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("post_rst_en", sgpr_rd_en, 0);
            chk("post_rst_busy", req_busy, 0);
            next();
        end

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
